// File: rtl/raster_mem_shim.sv
//============================================================================
// Module   : raster_mem_shim
// Purpose  : Takes ADC words from the raster scan controller over a 4-phase
//            handshake (data / mem_commit / mem_finished). Each word is
//            sign-extended and written into a circular word buffer in RAM
//            through a request/acknowledge write port. The host drains the
//            ring by moving rd_idx. The raster is stalled while the ring is
//            full.
// Ports    : clk, rst (async, active high), clear (sync restart, IDLE only)
//            data, mem_commit, mem_finished  - raster handshake
//            ram_req, ram_addr, ram_wdata, ram_ack - RAM write port
//            rd_idx (host), wr_idx, full, total_words, overflow - ring status
// Options  : RASTER_MEM_SHIM_DROP_EN - when defined, a commit that arrives
//            while the ring is full is discarded and flagged in overflow,
//            instead of stalling the raster.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module raster_mem_shim #(
    parameter int unsigned DAT_WID   = 24,
    parameter int unsigned BUS_WID   = 32,
    parameter int unsigned ADDR_WID  = 16,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned BUF_WORDS = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic [DAT_WID-1:0]  data,
    input  logic                mem_commit,
    output logic                mem_finished,
    output logic                ram_req,
    output logic [ADDR_WID-1:0] ram_addr,
    output logic [BUS_WID-1:0]  ram_wdata,
    input  logic                ram_ack,
    input  logic [ADDR_WID-1:0] rd_idx,
    output logic [ADDR_WID-1:0] wr_idx,
    output logic                full,
    output logic [31:0]         total_words,
    output logic                overflow
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_SPACE = 2'd1,
        S_WRITE      = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    localparam logic [ADDR_WID-1:0] c_LAST_IDX = ADDR_WID'(BUF_WORDS - 1);
    localparam logic [ADDR_WID-1:0] c_BASE     = ADDR_WID'(BASE_ADDR);
    localparam logic [ADDR_WID-1:0] c_ONE      = ADDR_WID'(1);

    state_t              r_state;
    logic                r_fin;
    logic                r_req;
    logic [ADDR_WID-1:0] r_addr;
    logic [BUS_WID-1:0]  r_wdata;
    logic [ADDR_WID-1:0] r_wr_idx;
    logic [31:0]         r_total;
    logic                r_ovf;
`ifndef RASTER_MEM_SHIM_DROP_EN
    // Bit 16 set means the current stall has lasted 2^16 cycles.
    logic [16:0]         r_stall_cnt;
`endif

    logic [ADDR_WID-1:0] w_rd_eff;
    logic [ADDR_WID-1:0] w_wr_next;
    logic                w_full;

    // An out-of-range host index is treated as slot 0. One slot always stays
    // empty, so "full" means the next write slot would collide with the reader.
    always_comb begin
        w_rd_eff  = (32'(rd_idx) >= BUF_WORDS) ? '0 : rd_idx;
        w_wr_next = (r_wr_idx == c_LAST_IDX) ? '0 : (r_wr_idx + c_ONE);
        w_full    = (w_wr_next == w_rd_eff);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fin       <= 1'b0;
            r_req       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wr_idx    <= '0;
            r_total     <= '0;
            r_ovf       <= 1'b0;
`ifndef RASTER_MEM_SHIM_DROP_EN
            r_stall_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clear) begin
                        r_wr_idx <= '0;
                        r_total  <= '0;
                        r_ovf    <= 1'b0;
                    end else if (mem_commit) begin
                        r_wdata <= BUS_WID'(signed'(data));
                        if (!w_full) begin
                            r_state <= S_WRITE;
                        end else begin
`ifdef RASTER_MEM_SHIM_DROP_EN
                            // Word is discarded; the raster still sees a
                            // normal completion so it keeps scanning.
                            r_ovf   <= 1'b1;
                            r_fin   <= 1'b1;
                            r_state <= S_DONE;
`else
                            r_stall_cnt <= '0;
                            r_state     <= S_WAIT_SPACE;
`endif
                        end
                    end
                end

                S_WAIT_SPACE: begin
                    if (!w_full) begin
                        r_state <= S_WRITE;
                    end
`ifndef RASTER_MEM_SHIM_DROP_EN
                    else if (!r_stall_cnt[16]) begin
                        r_stall_cnt <= r_stall_cnt + 17'd1;
                    end else begin
                        r_ovf <= 1'b1;
                    end
`endif
                end

                S_WRITE: begin
                    // First WRITE cycle launches the request; the address is
                    // captured here and held until the acknowledge.
                    if (!r_req) begin
                        r_req  <= 1'b1;
                        r_addr <= c_BASE + r_wr_idx;
                    end else if (ram_ack) begin
                        r_req    <= 1'b0;
                        r_wr_idx <= w_wr_next;
                        if (r_total != 32'hFFFF_FFFF) begin
                            r_total <= r_total + 32'd1;
                        end
                        r_fin    <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end

                S_DONE: begin
                    // A commit dropped early lands here immediately after the
                    // write completes, which is the intended recovery.
                    if (!mem_commit) begin
                        r_fin   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_finished = r_fin;
    assign ram_req      = r_req;
    assign ram_addr     = r_addr;
    assign ram_wdata    = r_wdata;
    assign wr_idx       = r_wr_idx;
    assign full         = w_full;
    assign total_words  = r_total;
    assign overflow     = r_ovf;

endmodule

`default_nettype wire
